// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the write-back source selector.
package rv32i_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU
  } wb_src_e;
endpackage

// File: rtl/writeback_unit_if.sv
// Producer-side handshakes into the write-back unit: ALU results and LSU load beats.
interface writeback_unit_if
  import rv32i_pkg::*;
#(
  parameter int XLEN = rv32i_pkg::XLEN
);
  logic                  alu_valid;
  logic                  alu_ready;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;

  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]       lsu_data;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready
  );
endinterface

// File: rtl/wb_fifo.sv
// Small first-word-fall-through FIFO holding {rd, data} load entries.
// DEPTH is a power of two so the pointers wrap naturally modulo DEPTH.
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head
);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem[rd_ptr_reg];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end
endmodule

// File: rtl/writeback_unit.sv
// Merges ALU results and buffered LSU loads onto the register file write port,
// and tracks outstanding loads for decode hazard checks.
module writeback_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN           = rv32i_pkg::XLEN,
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_unit_if.slave       bus,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [REG_ADDR_W-1:0] iss_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rs1_fwd_hit,
  output logic                  rs2_fwd_hit,
  output logic [XLEN-1:0]       rs1_fwd_data,
  output logic [XLEN-1:0]       rs2_fwd_data,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3
);
  localparam int ENTRY_W = REG_ADDR_W + XLEN;
  localparam int CNT_W   = $clog2(LSU_FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LSU_FIFO_DEPTH);

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    fifo_head;
  logic [REG_ADDR_W-1:0] head_rd;
  logic [XLEN-1:0]       head_data;

  wb_src_e               src;
  logic [REG_ADDR_W-1:0] commit_rd;
  logic [XLEN-1:0]       commit_data;

  logic                  we3_reg;
  logic [REG_ADDR_W-1:0] a3_reg;
  logic [XLEN-1:0]       wd3_reg;
  logic [NUM_REGS-1:0]   pending_reg;
  logic [NUM_REGS-1:0]   pending_next;

  // A load only enters the FIFO; it can reach the write port from the next cycle on.
  assign bus.lsu_ready = (fifo_count < DEPTH_C) & ~rst;
  assign bus.alu_ready = ~fifo_full & ~rst;
  assign fifo_push     = bus.lsu_valid & bus.lsu_ready;
  assign fifo_pop      = (src == WB_LSU);
  assign head_rd       = fifo_head[ENTRY_W-1 -: REG_ADDR_W];
  assign head_data     = fifo_head[XLEN-1:0];

  wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({bus.lsu_rd, bus.lsu_data}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // Arbitration: a full FIFO drains first so loads cannot starve, otherwise ALU wins.
  always_comb begin
    src         = WB_NONE;
    commit_rd   = bus.alu_rd;
    commit_data = bus.alu_data;
    if (!rst) begin
      if (fifo_full) begin
        src = WB_LSU;
      end else if (bus.alu_valid) begin
        src = WB_ALU;
      end else if (!fifo_empty) begin
        src = WB_LSU;
      end
    end
    if (src == WB_LSU) begin
      commit_rd   = head_rd;
      commit_data = head_data;
    end
  end

  // Write port register; x0 commits still move A3/WD3 but never assert WE3.
  always_ff @(posedge clk) begin
    if (rst) begin
      we3_reg <= 1'b0;
      a3_reg  <= '0;
      wd3_reg <= '0;
    end else if (src != WB_NONE) begin
      we3_reg <= (commit_rd != '0);
      a3_reg  <= commit_rd;
      wd3_reg <= commit_data;
    end else begin
      we3_reg <= 1'b0;
    end
  end

  // Per-register pending bit: a new long issue overrides a same-cycle load retire.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
    if (gi == 0) begin : g_x0
      assign pending_next[gi] = 1'b0;
    end else begin : g_rn
      assign pending_next[gi] =
          (iss_valid & iss_long & (iss_rd == REG_ADDR_W'(gi))) |
          (pending_reg[gi] & ~(fifo_pop & (head_rd == REG_ADDR_W'(gi))));
    end
  end

  // Scoreboard state register.
  always_ff @(posedge clk) begin
    if (rst) pending_reg <= '0;
    else     pending_reg <= pending_next;
  end

  assign rs1_busy     = pending_reg[rs1];
  assign rs2_busy     = pending_reg[rs2];
  assign rs1_fwd_hit  = we3_reg & (a3_reg == rs1) & (rs1 != '0);
  assign rs2_fwd_hit  = we3_reg & (a3_reg == rs2) & (rs2 != '0);
  assign rs1_fwd_data = rs1_fwd_hit ? wd3_reg : '0;
  assign rs2_fwd_data = rs2_fwd_hit ? wd3_reg : '0;

  assign WE3 = we3_reg;
  assign A3  = a3_reg;
  assign WD3 = wd3_reg;
endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed vector table, hand sequences for set-wins
// and mid-operation reset, then randomized traffic against a queue-based model.
module tb_writeback_unit;
  localparam int DEPTH = 2;

  typedef struct {
    logic        rst;
    logic        av;  logic [4:0] ard; logic [31:0] adat;
    logic        lv;  logic [4:0] lrd; logic [31:0] ldat;
    logic        iv;  logic       il;  logic [4:0]  ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        we;  logic [4:0] a3;  logic [31:0] wd;
    logic        ar;  logic       lr;
    logic        b1;  logic       b2;  logic        h1; logic h2;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_long;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy, rs1_fwd_hit, rs2_fwd_hit;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;

  int total = 0;
  int bad   = 0;

  writeback_unit_if #(.XLEN(32)) bus ();

  writeback_unit #(.XLEN(32), .LSU_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .iss_valid(iss_valid), .iss_long(iss_long), .iss_rd(iss_rd),
    .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd_hit(rs1_fwd_hit), .rs2_fwd_hit(rs2_fwd_hit),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference model: the load buffer as a queue, pending bits as a plain vector.
  logic [36:0] mq[$];
  logic [31:0] mpend;
  logic        mwe;
  logic [4:0]  ma3;
  logic [31:0] mwd;
  logic        m_lsu_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_step(input vec_t v);
    logic        full;
    logic [36:0] e;
    m_lsu_acc = 1'b0;
    if (v.rst) begin
      mq.delete();
      mpend = '0; mwe = 1'b0; ma3 = '0; mwd = '0;
    end else begin
      full = (mq.size() == DEPTH);
      if (full || (!v.av && mq.size() != 0)) begin
        e = mq.pop_front();
        mwe = (e[36:32] != 0); ma3 = e[36:32]; mwd = e[31:0];
        mpend[e[36:32]] = 1'b0;
      end else if (v.av) begin
        mwe = (v.ard != 0); ma3 = v.ard; mwd = v.adat;
      end else begin
        mwe = 1'b0;
      end
      if (v.iv && v.il && v.ird != 0) mpend[v.ird] = 1'b1;
      if (v.lv && !full) begin
        mq.push_back({v.lrd, v.ldat});
        m_lsu_acc = 1'b1;
      end
    end
  endtask

  task automatic model_check(input vec_t v, input string tag);
    logic rdy, h1, h2;
    rdy = !v.rst && (mq.size() < DEPTH);
    h1  = mwe && (ma3 == v.r1) && (v.r1 != 0);
    h2  = mwe && (ma3 == v.r2) && (v.r2 != 0);
    chk({tag, ".m.we"},   32'(WE3), 32'(mwe));
    chk({tag, ".m.a3"},   32'(A3), 32'(ma3));
    chk({tag, ".m.wd"},   WD3, mwd);
    chk({tag, ".m.ardy"}, 32'(bus.alu_ready), 32'(rdy));
    chk({tag, ".m.lrdy"}, 32'(bus.lsu_ready), 32'(rdy));
    chk({tag, ".m.b1"},   32'(rs1_busy), 32'(mpend[v.r1]));
    chk({tag, ".m.b2"},   32'(rs2_busy), 32'(mpend[v.r2]));
    chk({tag, ".m.h1"},   32'(rs1_fwd_hit), 32'(h1));
    chk({tag, ".m.h2"},   32'(rs2_fwd_hit), 32'(h2));
    chk({tag, ".m.f1"},   rs1_fwd_data, h1 ? mwd : 32'h0);
    chk({tag, ".m.f2"},   rs2_fwd_data, h2 ? mwd : 32'h0);
  endtask

  // Drive one cycle's inputs and move to the sampling point (negedge).
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst;
    bus.alu_valid = v.av; bus.alu_rd = v.ard; bus.alu_data = v.adat;
    bus.lsu_valid = v.lv; bus.lsu_rd = v.lrd; bus.lsu_data = v.ldat;
    iss_valid = v.iv; iss_long = v.il; iss_rd = v.ird;
    rs1 = v.r1; rs2 = v.r2;
    @(negedge clk);
    model_check(v, tag);
    if (WE3) $display("%s: write x%0d <= %h", tag, A3, WD3);
    else     $display("%s: no write", tag);
  endtask

  // Close the cycle: clock edge, advance the model, step off the edge.
  task automatic finish(input vec_t v);
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  function automatic vec_t vin(logic r, logic av, logic [4:0] ard, logic [31:0] adat,
                               logic lv, logic [4:0] lrd, logic [31:0] ldat,
                               logic iv, logic il, logic [4:0] ird,
                               logic [4:0] r1, logic [4:0] r2);
    vec_t v;
    v.rst = r; v.av = av; v.ard = ard; v.adat = adat;
    v.lv = lv; v.lrd = lrd; v.ldat = ldat;
    v.iv = iv; v.il = il; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.we = 0; v.a3 = 0; v.wd = 0; v.ar = 0; v.lr = 0;
    v.b1 = 0; v.b2 = 0; v.h1 = 0; v.h2 = 0;
    return v;
  endfunction

  function automatic vec_t vexp(vec_t v, logic we, logic [4:0] a3, logic [31:0] wd,
                                logic ar, logic lr, logic b1, logic b2, logic h1, logic h2);
    vec_t o = v;
    o.we = we; o.a3 = a3; o.wd = wd; o.ar = ar; o.lr = lr;
    o.b1 = b1; o.b2 = b2; o.h1 = h1; o.h2 = h2;
    return o;
  endfunction

  vec_t tbl[16];
  vec_t v;
  logic        hold;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;

  initial begin
    // Directed table: inputs for the cycle, then expected outputs in that cycle.
    tbl[0]  = vexp(vin(1,1,3,32'h33,1,4,32'h44,0,0,0,0,0),     0,0,32'h0,      0,0,0,0,0,0);
    tbl[1]  = vexp(vin(1,1,3,32'h33,1,4,32'h44,0,0,0,0,0),     0,0,32'h0,      0,0,0,0,0,0);
    tbl[2]  = vexp(vin(0,1,5,32'hAA,0,0,0,0,0,0,5,0),          0,0,32'h0,      1,1,0,0,0,0);
    tbl[3]  = vexp(vin(0,0,0,0,0,0,0,1,1,7,5,7),               1,5,32'hAA,     1,1,0,0,1,0);
    tbl[4]  = vexp(vin(0,0,0,0,1,7,32'h1234,0,0,0,5,7),        0,5,32'hAA,     1,1,0,1,0,0);
    tbl[5]  = vexp(vin(0,0,0,0,0,0,0,0,0,0,7,7),               0,5,32'hAA,     1,1,1,1,0,0);
    tbl[6]  = vexp(vin(0,0,0,0,0,0,0,0,0,0,7,7),               1,7,32'h1234,   1,1,0,0,1,1);
    tbl[7]  = vexp(vin(0,1,10,32'hA0,1,1,32'h101,0,0,0,0,0),   0,7,32'h1234,   1,1,0,0,0,0);
    tbl[8]  = vexp(vin(0,1,11,32'hA1,1,2,32'h102,0,0,0,0,0),   1,10,32'hA0,    1,1,0,0,0,0);
    tbl[9]  = vexp(vin(0,1,12,32'hA2,1,3,32'h103,0,0,0,0,0),   1,11,32'hA1,    0,0,0,0,0,0);
    tbl[10] = vexp(vin(0,1,12,32'hA2,1,3,32'h103,0,0,0,0,0),   1,1,32'h101,    1,1,0,0,0,0);
    tbl[11] = vexp(vin(0,1,13,32'hA3,0,0,0,0,0,0,0,0),         1,12,32'hA2,    0,0,0,0,0,0);
    tbl[12] = vexp(vin(0,1,13,32'hA3,0,0,0,0,0,0,0,0),         1,2,32'h102,    1,1,0,0,0,0);
    tbl[13] = vexp(vin(0,0,0,0,0,0,0,0,0,0,0,0),               1,13,32'hA3,    1,1,0,0,0,0);
    tbl[14] = vexp(vin(0,1,0,32'hFFFF_FFFF,0,0,0,1,1,0,0,0),   1,3,32'h103,    1,1,0,0,0,0);
    tbl[15] = vexp(vin(0,0,0,0,0,0,0,0,0,0,0,0),               0,0,32'hFFFF_FFFF,1,1,0,0,0,0);

    // First reset edge: outputs are unknown before it, so nothing is sampled.
    v = vin(1,1,3,32'h33,1,4,32'h44,0,0,0,0,0);
    rst = 1'b1;
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h33;
    bus.lsu_valid = 1; bus.lsu_rd = 4; bus.lsu_data = 32'h44;
    iss_valid = 0; iss_long = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    @(posedge clk);
    model_step(v);
    #1;

    for (int i = 0; i < 16; i++) begin
      string t;
      t = $sformatf("row%0d", i);
      apply(tbl[i], t);
      chk({t, ".we"},   32'(WE3), 32'(tbl[i].we));
      chk({t, ".a3"},   32'(A3), 32'(tbl[i].a3));
      chk({t, ".wd"},   WD3, tbl[i].wd);
      chk({t, ".ardy"}, 32'(bus.alu_ready), 32'(tbl[i].ar));
      chk({t, ".lrdy"}, 32'(bus.lsu_ready), 32'(tbl[i].lr));
      chk({t, ".b1"},   32'(rs1_busy), 32'(tbl[i].b1));
      chk({t, ".b2"},   32'(rs2_busy), 32'(tbl[i].b2));
      chk({t, ".h1"},   32'(rs1_fwd_hit), 32'(tbl[i].h1));
      chk({t, ".h2"},   32'(rs2_fwd_hit), 32'(tbl[i].h2));
      chk({t, ".f1"},   rs1_fwd_data, tbl[i].h1 ? tbl[i].wd : 32'h0);
      finish(tbl[i]);
    end

    // Set-wins: load for x9 retires in the same cycle a new long issue targets x9.
    v = vin(0,0,0,0,1,9,32'h99,1,1,9,9,0);     apply(v, "sw0"); finish(v);
    v = vin(0,0,0,0,0,0,0,1,1,9,9,0);          apply(v, "sw1"); finish(v);
    v = vin(0,1,21,32'h21,1,20,32'h20,0,0,0,9,0);
    apply(v, "sw2");
    chk("sw2.we", 32'(WE3), 32'd1);
    chk("sw2.a3", 32'(A3), 32'd9);
    chk("sw2.wd", WD3, 32'h99);
    chk("sw2.busy9", 32'(rs1_busy), 32'd1);
    finish(v);

    // Reset with two loads buffered: nothing may reach the write port afterwards.
    v = vin(0,1,23,32'h23,1,22,32'h22,0,0,0,0,0); apply(v, "rm0"); finish(v);
    v = vin(1,0,0,0,0,0,0,0,0,0,20,9);
    apply(v, "rm1");
    chk("rm1.ardy", 32'(bus.alu_ready), 32'd0);
    chk("rm1.lrdy", 32'(bus.lsu_ready), 32'd0);
    finish(v);
    v = vin(0,0,0,0,0,0,0,0,0,0,20,9);
    for (int k = 0; k < 3; k++) begin
      string t;
      t = $sformatf("rm%0d", k + 2);
      apply(v, t);
      chk({t, ".we"}, 32'(WE3), 32'd0);
      chk({t, ".busy9"}, 32'(rs2_busy), 32'd0);
      chk({t, ".lrdy"}, 32'(bus.lsu_ready), 32'd1);
      if (k == 0) begin
        chk("rm2.a3", 32'(A3), 32'd0);
        chk("rm2.wd", WD3, 32'h0);
      end
      finish(v);
    end

    // Randomized traffic; a refused load beat is held until accepted.
    hold = 1'b0; hold_rd = '0; hold_data = '0;
    for (int n = 0; n < 1500; n++) begin
      v = vin(($urandom_range(0, 63) == 0),
              ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom,
              1'b0, 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
              5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (hold) begin
        v.lv = 1'b1; v.lrd = hold_rd; v.ldat = hold_data;
      end else begin
        v.lv = ($urandom_range(0, 2) == 0);
      end
      apply(v, $sformatf("rnd%0d", n));
      finish(v);
      hold = v.lv && !m_lsu_acc;
      hold_rd = v.lrd; hold_data = v.ldat;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
Write-side driver of the RV32I register file. It merges single-cycle ALU results and handshaked LSU load data into the register file's single write port (WE3/A3/WD3). It buffers LSU data in a small FIFO and keeps a pending-load scoreboard for decode-stage hazard detection. It sits between the execute/memory stages and the register file write port.

Parameters:
XLEN, 32, data width of results and WD3
LSU_FIFO_DEPTH, 2, LSU buffer entries; allowed values are 2, 4 or 8

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
alu_valid  in  1  ALU result present this cycle
alu_ready  out  1  ALU result accepted this cycle
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
lsu_valid  in  1  load data present
lsu_ready  out  1  FIFO can accept a load
lsu_rd  in  5  load destination register
lsu_data  in  XLEN  load data
iss_valid  in  1  decode issued an instruction
iss_long  in  1  issued instruction is a load; marks rd pending
iss_rd  in  5  issued destination register
rs1  in  5  decode source 1 query
rs2  in  5  decode source 2 query
rs1_busy  out  1  pending load targets rs1
rs2_busy  out  1  pending load targets rs2
rs1_fwd_hit  out  1  write port is writing rs1 this cycle
rs2_fwd_hit  out  1  write port is writing rs2 this cycle
rs1_fwd_data  out  XLEN  equals WD3 when rs1_fwd_hit, else 0
rs2_fwd_data  out  XLEN  equals WD3 when rs2_fwd_hit, else 0
WE3  out  1  register file write enable (registered)
A3  out  5  register file write address (registered)
WD3  out  XLEN  register file write data (registered)

Behaviour:
- Clock and reset: one clock, clk; reset is rst, synchronous, active-high.
- Reset (rst=1 at a clk edge):
  - WE3=0, A3=0, WD3=0.
  - FIFO emptied; pending[31:0]=0.
  - While rst=1, alu_ready=0 and lsu_ready=0 (combinationally forced).
  - Reset mid-operation discards buffered loads and pending bits with no write.
- LSU handshake:
  - Transfer occurs when lsu_valid & lsu_ready.
  - lsu_ready = (count < LSU_FIFO_DEPTH) & !rst.
  - lsu_rd and lsu_data must be held stable while lsu_valid=1 and lsu_ready=0.
- Write-port arbitration, evaluated each cycle:
  - FIFO full (count==DEPTH): the FIFO head commits and alu_ready=0, so the ALU stalls.
  - Otherwise, if alu_valid: the ALU commits and alu_ready=1.
  - Otherwise, if the FIFO is non-empty: the FIFO head commits.
  - alu_ready=1 whenever the FIFO is not full and rst=0.
  - Simultaneous push and pop in one cycle are both legal; count is unchanged.
- Bypass path:
  - An accepted LSU beat may not bypass the FIFO.
  - It commits no earlier than the cycle after the push, so load-to-write latency is at least 2 cycles.
- Write port:
  - The committed source's rd/data are registered into A3/WD3 at the next edge.
  - WE3 = 1 when a commit occurred and rd != 0.
  - A commit to x0 produces WE3=0; A3/WD3 still update.
  - With no commit, WE3=0 and A3/WD3 hold their values.
  - ALU latency: one cycle from acceptance to WE3.
- Scoreboard:
  - Set pending[iss_rd] when iss_valid & iss_long & iss_rd != 0.
  - Clear pending[rd] when a FIFO-head commit occurs.
  - Set and clear of the same rd in one cycle: set wins.
  - ALU commits never clear pending bits.
  - pending[0] is always 0.
- Queries (combinational):
  - rsN_busy = pending[rsN].
  - rsN_fwd_hit = WE3 & (A3 == rsN) & (rsN != 0).
  - The register file write lands at the same edge, so the forward covers the read-during-write cycle.
- FIFO pointers wrap modulo DEPTH. Count is DEPTH+1 states wide.
- Order: loads commit in acceptance order. ALU and LSU results have no mutual ordering guarantee; decode uses the busy bits for that.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN
  - REG_ADDR_W=5
  - NUM_REGS=32
  - a wb_src enum {WB_NONE, WB_ALU, WB_LSU}
- One sub-module, wb_fifo:
  - Synchronous FIFO parameterised by width and depth.
  - Ports: push, pop, full, empty, count, head.
  - Entries are {rd, data}.
- Arbitration, scoreboard and output registers live in writeback_unit.

Test Plan:
1. Reset:
   - Stimulus: assert rst for 2 cycles with lsu_valid=1 and alu_valid=1.
   - Response: WE3=0, A3=0, WD3=0, alu_ready=0, lsu_ready=0, all busy=0.
2. ALU path:
   - Stimulus: alu_valid, alu_rd=5, alu_data=0x0000_00AA.
   - Response: next cycle WE3=1, A3=5, WD3=0xAA. With rs1=5 in that cycle, rs1_fwd_hit=1 and rs1_fwd_data=0xAA.
3. Load with scoreboard:
   - Stimulus: iss_valid, iss_long, iss_rd=7, then lsu beat rd=7 data=0x1234.
   - Response: rs2_busy=1 when rs2=7 from the cycle after issue; WE3=1, A3=7, WD3=0x1234 two cycles after the beat; busy=0 after that commit.
4. Contention and full FIFO:
   - Stimulus: continuous alu_valid plus 3 back-to-back lsu beats (rd=1, 2, 3) at DEPTH=2.
   - Response: lsu_ready=0 on the 3rd beat until a pop. On the full cycle, alu_ready=0 and rd=1 commits. Loads commit in order 1, 2, 3, and no ALU result is lost.
5. x0 handling:
   - Stimulus: ALU commit with rd=0 data=0xFFFF_FFFF; issue iss_long iss_rd=0.
   - Response: WE3=0; rs1=0 gives rs1_busy=0 and rs1_fwd_hit=0.
6. Set-wins and reset mid-operation:
   - Stimulus: FIFO-head commit rd=9 in the same cycle as issue long rd=9 → pending[9] stays 1. Then assert rst with 2 FIFO entries.
   - Response: after reset no WE3 pulse, FIFO empty, all pending bits clear.
